// File: rtl/reorder_buffer_pkg.sv
// Shared CPU types for the reorder buffer: ROB entry, writeback exception flags
// and the commit view handed to the rename table.
package reorder_buffer_pkg;

  localparam int unsigned ROB_DEPTH = 16;

  typedef struct packed {
    logic adel;
    logic ades;
    logic sys;
    logic brk;
    logic ri;
    logic ov;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  dest;
    logic [5:0]  old_dest;
    logic [5:0]  phy_dest;
    exception_t  exception;
    logic        eret;
    logic        priv;
  } rob_entry_t;

  typedef struct packed {
    logic       rf_we;
    logic [4:0] dest;
    logic [5:0] old_dest;
    logic [5:0] phy_dest;
  } commit_to_rat_bus_t;

  // Exceptions and eret both redirect the pipeline at retirement.
  function automatic logic traps(input rob_entry_t e);
    return (|e.exception) || e.eret;
  endfunction

  function automatic commit_to_rat_bus_t to_rat(input rob_entry_t e);
    commit_to_rat_bus_t c;
    c.rf_we    = e.rf_we && !traps(e);
    c.dest     = e.dest;
    c.old_dest = e.old_dest;
    c.phy_dest = e.phy_dest;
    return c;
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_select.sv
// Retire-enable selection for the two commit slots, looking at the head entry
// and the one behind it.
module rob_commit_select
  import reorder_buffer_pkg::*;
(
  input  logic       head_valid,
  input  logic       head_complete,
  input  exception_t head_exception,
  input  logic       head_eret,
  input  logic       head_priv,
  input  logic       next_valid,
  input  logic       next_complete,
  input  exception_t next_exception,
  input  logic       next_eret,
  input  logic       next_priv,
  output logic       retire1,
  output logic       retire2
);

  logic head_serial;
  logic next_serial;

  // Anything that may redirect or touch privileged state retires alone.
  assign head_serial = (|head_exception) || head_eret || head_priv;
  assign next_serial = (|next_exception) || next_eret || next_priv;

  assign retire1 = head_valid && head_complete;
  assign retire2 = retire1 && next_valid && next_complete && !head_serial && !next_serial;

endmodule

// File: rtl/reorder_buffer.sv
// Dual-issue reorder buffer: in-order allocation of instruction pairs,
// out-of-order completion, in-order retirement of up to two per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
  parameter int unsigned IDX_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               ds_to_rob_valid,
  output logic               rob_allowin,
  input  rob_entry_t         map_to_rob_bus1,
  input  rob_entry_t         map_to_rob_bus2,
  output logic [IDX_W-1:0]   rob_tail_o,
  output logic               rob_empty,
  input  logic               wb_valid1,
  input  logic               wb_valid2,
  input  logic [IDX_W-1:0]   wb_rob_idx1,
  input  logic [IDX_W-1:0]   wb_rob_idx2,
  input  exception_t         wb_exception1,
  input  exception_t         wb_exception2,
  output commit_to_rat_bus_t commit_to_rat_bus1,
  output commit_to_rat_bus_t commit_to_rat_bus2,
  output logic               commit_flush,
  output logic [31:0]        commit_epc
);

  localparam logic [IDX_W:0] ALLOC_LIMIT = (IDX_W+1)'(ROB_DEPTH - 2);

  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [IDX_W:0]       count;
  logic [ROB_DEPTH-1:0] valid;
  logic [ROB_DEPTH-1:0] complete;
  rob_entry_t           mem [ROB_DEPTH];

  logic [IDX_W-1:0]     head_next_idx;
  logic [IDX_W-1:0]     bus2_idx;
  rob_entry_t           head_entry;
  rob_entry_t           next_entry;
  logic                 retire1;
  logic                 retire2;
  logic                 trap;
  logic                 alloc;
  logic [1:0]           alloc_cnt;
  logic [1:0]           retire_cnt;
  logic [ROB_DEPTH-1:0] wb_hit1;
  logic [ROB_DEPTH-1:0] wb_hit2;

  assign head_next_idx = head + IDX_W'(1);
  assign bus2_idx      = map_to_rob_bus1.valid ? tail + IDX_W'(1) : tail;

  always_comb begin
    head_entry       = mem[head];
    head_entry.valid = valid[head] && mem[head].valid;
    next_entry       = mem[head_next_idx];
    next_entry.valid = valid[head_next_idx] && mem[head_next_idx].valid;
  end

  rob_commit_select u_commit_select (
    .head_valid     (head_entry.valid),
    .head_complete  (complete[head]),
    .head_exception (head_entry.exception),
    .head_eret      (head_entry.eret),
    .head_priv      (head_entry.priv),
    .next_valid     (next_entry.valid),
    .next_complete  (complete[head_next_idx]),
    .next_exception (next_entry.exception),
    .next_eret      (next_entry.eret),
    .next_priv      (next_entry.priv),
    .retire1        (retire1),
    .retire2        (retire2)
  );

  assign trap        = retire1 && traps(head_entry);
  assign rob_allowin = (count <= ALLOC_LIMIT) && !commit_flush;
  assign rob_empty   = (count == '0);
  assign rob_tail_o  = tail;
  assign alloc       = ds_to_rob_valid && rob_allowin;
  assign alloc_cnt   = alloc ? ({1'b0, map_to_rob_bus1.valid} + {1'b0, map_to_rob_bus2.valid}) : 2'd0;
  assign retire_cnt  = {1'b0, retire1} + {1'b0, retire2};

  always_comb begin
    wb_hit1 = '0;
    wb_hit2 = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      wb_hit1[i] = wb_valid1 && valid[i] && (wb_rob_idx1 == IDX_W'(i));
      wb_hit2[i] = wb_valid2 && valid[i] && (wb_rob_idx2 == IDX_W'(i));
    end
  end

  // Later bit-level assignments deliberately override the vector-wide
  // writeback update: retirement clears, then allocation re-arms a slot.
  always_ff @(posedge clk) begin
    if (reset || flush || trap) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      complete <= complete | wb_hit1 | wb_hit2;
      if (retire1) begin
        valid[head]    <= 1'b0;
        complete[head] <= 1'b0;
      end
      if (retire2) begin
        valid[head_next_idx]    <= 1'b0;
        complete[head_next_idx] <= 1'b0;
      end
      if (alloc && map_to_rob_bus1.valid) begin
        valid[tail]    <= 1'b1;
        complete[tail] <= 1'b0;
      end
      if (alloc && map_to_rob_bus2.valid) begin
        valid[bus2_idx]    <= 1'b1;
        complete[bus2_idx] <= 1'b0;
      end
      head  <= head + IDX_W'(retire_cnt);
      tail  <= tail + IDX_W'(alloc_cnt);
      count <= count + (IDX_W+1)'(alloc_cnt) - (IDX_W+1)'(retire_cnt);
    end
  end

  // Payload needs no reset: the valid vector gates every use of it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      if (wb_hit1[i] || wb_hit2[i]) begin
        mem[i].exception <= mem[i].exception
                          | (wb_hit1[i] ? wb_exception1 : exception_t'('0))
                          | (wb_hit2[i] ? wb_exception2 : exception_t'('0));
      end
    end
    if (alloc && map_to_rob_bus1.valid) mem[tail]     <= map_to_rob_bus1;
    if (alloc && map_to_rob_bus2.valid) mem[bus2_idx] <= map_to_rob_bus2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_to_rat_bus1 <= '0;
      commit_to_rat_bus2 <= '0;
      commit_flush       <= 1'b0;
      commit_epc         <= '0;
    end else if (flush) begin
      commit_to_rat_bus1 <= '0;
      commit_to_rat_bus2 <= '0;
      commit_flush       <= 1'b0;
    end else begin
      commit_to_rat_bus1 <= retire1 ? to_rat(head_entry) : '0;
      commit_to_rat_bus2 <= retire2 ? to_rat(next_entry) : '0;
      commit_flush       <= trap;
      if (trap) commit_epc <= head_entry.pc;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a program-order queue model of the buffer.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               ds_to_rob_valid;
  logic               rob_allowin;
  rob_entry_t         map_to_rob_bus1;
  rob_entry_t         map_to_rob_bus2;
  logic [3:0]         rob_tail_o;
  logic               rob_empty;
  logic               wb_valid1;
  logic               wb_valid2;
  logic [3:0]         wb_rob_idx1;
  logic [3:0]         wb_rob_idx2;
  exception_t         wb_exception1;
  exception_t         wb_exception2;
  commit_to_rat_bus_t commit_to_rat_bus1;
  commit_to_rat_bus_t commit_to_rat_bus2;
  logic               commit_flush;
  logic [31:0]        commit_epc;

  int tests = 0;
  int fails = 0;

  typedef struct {
    rob_entry_t e;
    bit         complete;
  } ment_t;

  ment_t              q[$];
  int                 mhead;
  commit_to_rat_bus_t exp_b1;
  commit_to_rat_bus_t exp_b2;
  logic               exp_cf;
  logic [31:0]        exp_epc;

  reorder_buffer #(.ROB_DEPTH(16), .IDX_W(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .ds_to_rob_valid    (ds_to_rob_valid),
    .rob_allowin        (rob_allowin),
    .map_to_rob_bus1    (map_to_rob_bus1),
    .map_to_rob_bus2    (map_to_rob_bus2),
    .rob_tail_o         (rob_tail_o),
    .rob_empty          (rob_empty),
    .wb_valid1          (wb_valid1),
    .wb_valid2          (wb_valid2),
    .wb_rob_idx1        (wb_rob_idx1),
    .wb_rob_idx2        (wb_rob_idx2),
    .wb_exception1      (wb_exception1),
    .wb_exception2      (wb_exception2),
    .commit_to_rat_bus1 (commit_to_rat_bus1),
    .commit_to_rat_bus2 (commit_to_rat_bus2),
    .commit_flush       (commit_flush),
    .commit_epc         (commit_epc)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rob_entry_t mk(input logic [31:0] pc, input int n);
    rob_entry_t e;
    e          = '0;
    e.valid    = 1'b1;
    e.pc       = pc;
    e.rf_we    = 1'b1;
    e.dest     = 5'(n + 1);
    e.old_dest = 6'(n);
    e.phy_dest = 6'(n + 32);
    return e;
  endfunction

  function automatic rob_entry_t rand_entry();
    rob_entry_t e;
    e.valid     = ($urandom_range(0, 4) != 0);
    e.pc        = $urandom & 32'hffff_fffc;
    e.rf_we     = 1'($urandom);
    e.dest      = 5'($urandom);
    e.old_dest  = 6'($urandom);
    e.phy_dest  = 6'($urandom);
    e.exception = ($urandom_range(0, 31) == 0) ? exception_t'(6'($urandom_range(1, 63))) : '0;
    e.eret      = ($urandom_range(0, 63) == 0);
    e.priv      = ($urandom_range(0, 31) == 0);
    return e;
  endfunction

  function automatic commit_to_rat_bus_t rat_view(input rob_entry_t e);
    commit_to_rat_bus_t c;
    c.rf_we    = e.rf_we && (e.exception == '0) && !e.eret;
    c.dest     = e.dest;
    c.old_dest = e.old_dest;
    c.phy_dest = e.phy_dest;
    return c;
  endfunction

  function automatic bit solo(input rob_entry_t e);
    return (e.exception != '0) || e.eret || e.priv;
  endfunction

  function automatic bit exp_allow();
    return (q.size() <= 14) && !exp_cf;
  endfunction

  function automatic logic [3:0] exp_tail();
    return 4'((mhead + q.size()) % 16);
  endfunction

  // Advances the program-order model by one clock using the inputs now driven.
  task automatic model_step();
    bit    r1, r2, trap, allow;
    ment_t m;
    if (reset) begin
      q.delete(); mhead = 0;
      exp_b1 = '0; exp_b2 = '0; exp_cf = 1'b0; exp_epc = '0;
      return;
    end
    if (flush) begin
      q.delete(); mhead = 0;
      exp_b1 = '0; exp_b2 = '0; exp_cf = 1'b0;
      return;
    end
    allow  = exp_allow();
    r1     = (q.size() > 0) && q[0].complete;
    r2     = r1 && (q.size() > 1) && q[1].complete && !solo(q[0].e) && !solo(q[1].e);
    trap   = r1 && ((q[0].e.exception != '0) || q[0].e.eret);
    exp_b1 = r1 ? rat_view(q[0].e) : '0;
    exp_b2 = r2 ? rat_view(q[1].e) : '0;
    exp_cf = trap;
    if (trap) begin
      exp_epc = q[0].e.pc;
      q.delete(); mhead = 0;
      return;
    end
    for (int k = 0; k < q.size(); k++) begin
      m = q[k];
      if (wb_valid1 && (4'((mhead + k) % 16) == wb_rob_idx1)) begin
        m.complete    = 1'b1;
        m.e.exception = m.e.exception | wb_exception1;
      end
      if (wb_valid2 && (4'((mhead + k) % 16) == wb_rob_idx2)) begin
        m.complete    = 1'b1;
        m.e.exception = m.e.exception | wb_exception2;
      end
      q[k] = m;
    end
    if (r1) begin void'(q.pop_front()); mhead = (mhead + 1) % 16; end
    if (r2) begin void'(q.pop_front()); mhead = (mhead + 1) % 16; end
    if (ds_to_rob_valid && allow) begin
      if (map_to_rob_bus1.valid) q.push_back('{e: map_to_rob_bus1, complete: 1'b0});
      if (map_to_rob_bus2.valid) q.push_back('{e: map_to_rob_bus2, complete: 1'b0});
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; flush = 1'b0; ds_to_rob_valid = 1'b0;
    map_to_rob_bus1 = '0; map_to_rob_bus2 = '0;
    wb_valid1 = 1'b0; wb_valid2 = 1'b0; wb_rob_idx1 = '0; wb_rob_idx2 = '0;
    wb_exception1 = '0; wb_exception2 = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests++; if (rob_allowin !== 1'b1) begin fails++; $display("FAIL reset_allowin got %b want 1", rob_allowin); end
    tests++; if (rob_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", rob_empty); end
    tests++; if (rob_tail_o !== 4'd0) begin fails++; $display("FAIL reset_tail got %0d want 0", rob_tail_o); end
    tests++; if (commit_to_rat_bus1 !== '0) begin fails++; $display("FAIL reset_bus1 got %h want 0", commit_to_rat_bus1); end
    tests++; if (commit_to_rat_bus2 !== '0) begin fails++; $display("FAIL reset_bus2 got %h want 0", commit_to_rat_bus2); end
    tests++; if (commit_flush !== 1'b0) begin fails++; $display("FAIL reset_cflush got %b want 0", commit_flush); end
    tests++; if (commit_epc !== 32'h0) begin fails++; $display("FAIL reset_epc got %h want 0", commit_epc); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h100, 0);
    map_to_rob_bus2 = mk(32'h104, 1);
    tests++; if (rob_tail_o !== 4'd0) begin fails++; $display("FAIL pair_tail_before got %0d want 0", rob_tail_o); end
    step();
    drive_idle();
    tests++; if (rob_tail_o !== 4'd2) begin fails++; $display("FAIL pair_tail_after got %0d want 2", rob_tail_o); end
    tests++; if (rob_empty !== 1'b0) begin fails++; $display("FAIL pair_empty got %b want 0", rob_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int p = 0; p < 7; p++) begin
      ds_to_rob_valid = 1'b1;
      map_to_rob_bus1 = mk(32'h1000 + 32'(p * 8), 2 * p);
      map_to_rob_bus2 = mk(32'h1004 + 32'(p * 8), 2 * p + 1);
      step();
    end
    drive_idle();
    tests++; if (rob_allowin !== 1'b1) begin fails++; $display("FAIL full_allowin_14 got %b want 1", rob_allowin); end
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h1038, 14);
    step();
    drive_idle();
    tests++; if (rob_allowin !== 1'b0) begin fails++; $display("FAIL full_allowin_15 got %b want 0", rob_allowin); end
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h103c, 15);
    map_to_rob_bus2 = mk(32'h1040, 16);
    step();
    drive_idle();
    tests++; if (rob_tail_o !== 4'd15) begin fails++; $display("FAIL full_reject_tail got %0d want 15", rob_tail_o); end
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd0;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1.phy_dest !== 6'd32) begin fails++; $display("FAIL full_retire_phy got %0d want 32", commit_to_rat_bus1.phy_dest); end
    tests++; if (commit_to_rat_bus2 !== '0) begin fails++; $display("FAIL full_retire_bus2 got %h want 0", commit_to_rat_bus2); end
    tests++; if (rob_allowin !== 1'b1) begin fails++; $display("FAIL full_allowin_after got %b want 1", rob_allowin); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h300, 0);
    map_to_rob_bus2 = mk(32'h304, 1);
    step();
    drive_idle();
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd1;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1 !== '0) begin fails++; $display("FAIL ooo_hold_bus1 got %h want 0", commit_to_rat_bus1); end
    tests++; if (commit_to_rat_bus2 !== '0) begin fails++; $display("FAIL ooo_hold_bus2 got %h want 0", commit_to_rat_bus2); end
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd0;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1 !== {1'b1, 5'd1, 6'd0, 6'd32}) begin fails++; $display("FAIL ooo_bus1 got %h want %h", commit_to_rat_bus1, {1'b1, 5'd1, 6'd0, 6'd32}); end
    tests++; if (commit_to_rat_bus2 !== {1'b1, 5'd2, 6'd1, 6'd33}) begin fails++; $display("FAIL ooo_bus2 got %h want %h", commit_to_rat_bus2, {1'b1, 5'd2, 6'd1, 6'd33}); end
    tests++; if (rob_empty !== 1'b1) begin fails++; $display("FAIL ooo_empty got %b want 1", rob_empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive_idle();
      ds_to_rob_valid = 1'b1;
      map_to_rob_bus1 = mk(32'h400 + 32'(i * 4), i);
      wb_valid1       = (i > 0);
      wb_rob_idx1     = 4'(i - 1);
      step();
    end
    drive_idle();
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd14;
    step();
    drive_idle();
    step();
    step();
    tests++; if (rob_tail_o !== 4'd15) begin fails++; $display("FAIL wrap_drain_tail got %0d want 15", rob_tail_o); end
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h500, 20);
    map_to_rob_bus2 = mk(32'h504, 21);
    step();
    drive_idle();
    tests++; if (rob_tail_o !== 4'd1) begin fails++; $display("FAIL wrap_tail got %0d want 1", rob_tail_o); end
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd15;
    wb_valid2 = 1'b1; wb_rob_idx2 = 4'd0;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1.phy_dest !== 6'd52) begin fails++; $display("FAIL wrap_bus1_phy got %0d want 52", commit_to_rat_bus1.phy_dest); end
    tests++; if (commit_to_rat_bus2.phy_dest !== 6'd53) begin fails++; $display("FAIL wrap_bus2_phy got %0d want 53", commit_to_rat_bus2.phy_dest); end
    tests++; if (rob_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b want 1", rob_empty); end
  endtask

  task automatic test_exception();
    do_reset();
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h200, 2);
    map_to_rob_bus2 = mk(32'h204, 3);
    step();
    drive_idle();
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd0; wb_exception1.ov = 1'b1;
    wb_valid2 = 1'b1; wb_rob_idx2 = 4'd1;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1.rf_we !== 1'b0) begin fails++; $display("FAIL exc_rf_we got %b want 0", commit_to_rat_bus1.rf_we); end
    tests++; if (commit_to_rat_bus1.phy_dest !== 6'd34) begin fails++; $display("FAIL exc_phy got %0d want 34", commit_to_rat_bus1.phy_dest); end
    tests++; if (commit_to_rat_bus2 !== '0) begin fails++; $display("FAIL exc_bus2 got %h want 0", commit_to_rat_bus2); end
    tests++; if (commit_flush !== 1'b1) begin fails++; $display("FAIL exc_cflush got %b want 1", commit_flush); end
    tests++; if (commit_epc !== 32'h200) begin fails++; $display("FAIL exc_epc got %h want 200", commit_epc); end
    tests++; if (rob_empty !== 1'b1) begin fails++; $display("FAIL exc_empty got %b want 1", rob_empty); end
    tests++; if (rob_allowin !== 1'b0) begin fails++; $display("FAIL exc_allowin got %b want 0", rob_allowin); end
    step();
    tests++; if (commit_flush !== 1'b0) begin fails++; $display("FAIL exc_cflush_pulse got %b want 0", commit_flush); end
    tests++; if (rob_allowin !== 1'b1) begin fails++; $display("FAIL exc_allowin_after got %b want 1", rob_allowin); end
  endtask

  task automatic test_flush();
    do_reset();
    ds_to_rob_valid = 1'b1;
    map_to_rob_bus1 = mk(32'h600, 4);
    map_to_rob_bus2 = mk(32'h604, 5);
    step();
    flush = 1'b1;
    map_to_rob_bus1 = mk(32'h700, 6);
    map_to_rob_bus2 = mk(32'h704, 7);
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd0;
    wb_valid2 = 1'b1; wb_rob_idx2 = 4'd1;
    step();
    drive_idle();
    tests++; if (commit_to_rat_bus1 !== '0) begin fails++; $display("FAIL flush_bus1 got %h want 0", commit_to_rat_bus1); end
    tests++; if (commit_to_rat_bus2 !== '0) begin fails++; $display("FAIL flush_bus2 got %h want 0", commit_to_rat_bus2); end
    tests++; if (rob_empty !== 1'b1) begin fails++; $display("FAIL flush_empty got %b want 1", rob_empty); end
    tests++; if (rob_tail_o !== 4'd0) begin fails++; $display("FAIL flush_tail got %0d want 0", rob_tail_o); end
    wb_valid1 = 1'b1; wb_rob_idx1 = 4'd0;
    step();
    drive_idle();
    step();
    tests++; if (commit_to_rat_bus1 !== '0) begin fails++; $display("FAIL flush_stale_wb got %h want 0", commit_to_rat_bus1); end
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 499) == 0);
      flush           = ($urandom_range(0, 63) == 0);
      ds_to_rob_valid = ($urandom_range(0, 9) < 7);
      map_to_rob_bus1 = rand_entry();
      map_to_rob_bus2 = rand_entry();
      if ((q.size() > 0) && ($urandom_range(0, 3) != 0)) begin
        k = $urandom_range(0, q.size() - 1);
        wb_valid1 = 1'b1; wb_rob_idx1 = 4'((mhead + k) % 16);
      end else begin
        wb_valid1 = ($urandom_range(0, 7) == 0); wb_rob_idx1 = 4'($urandom);
      end
      if ((q.size() > 0) && ($urandom_range(0, 2) == 0)) begin
        k = $urandom_range(0, q.size() - 1);
        wb_valid2 = 1'b1; wb_rob_idx2 = 4'((mhead + k) % 16);
      end else begin
        wb_valid2 = 1'b0; wb_rob_idx2 = 4'($urandom);
      end
      wb_exception1 = ($urandom_range(0, 39) == 0) ? exception_t'(6'($urandom_range(1, 63))) : '0;
      wb_exception2 = ($urandom_range(0, 39) == 0) ? exception_t'(6'($urandom_range(1, 63))) : '0;
      tests++; if (rob_allowin !== exp_allow()) begin fails++; $display("FAIL rnd_allowin cyc %0d got %b want %b", c, rob_allowin, exp_allow()); end
      tests++; if (rob_tail_o !== exp_tail()) begin fails++; $display("FAIL rnd_tail cyc %0d got %0d want %0d", c, rob_tail_o, exp_tail()); end
      tests++; if (rob_empty !== (q.size() == 0)) begin fails++; $display("FAIL rnd_empty cyc %0d got %b want %b", c, rob_empty, q.size() == 0); end
      step();
      tests++; if (commit_to_rat_bus1 !== exp_b1) begin fails++; $display("FAIL rnd_bus1 cyc %0d got %h want %h", c, commit_to_rat_bus1, exp_b1); end
      tests++; if (commit_to_rat_bus2 !== exp_b2) begin fails++; $display("FAIL rnd_bus2 cyc %0d got %h want %h", c, commit_to_rat_bus2, exp_b2); end
      tests++; if (commit_flush !== exp_cf) begin fails++; $display("FAIL rnd_cflush cyc %0d got %b want %b", c, commit_flush, exp_cf); end
      tests++; if (commit_epc !== exp_epc) begin fails++; $display("FAIL rnd_epc cyc %0d got %h want %h", c, commit_epc, exp_epc); end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    q.delete(); mhead = 0;
    exp_b1 = '0; exp_b2 = '0; exp_cf = 1'b0; exp_epc = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_alloc_pair();
    test_full();
    test_out_of_order();
    test_wrap();
    test_exception();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
